// File: rtl/sfu_pkg.sv
// Shared SFU definitions used by the GELU LUT loader: loader FSM states,
// LUT RAM geometry and the base address of each GELU LUT segment.
package sfu_pkg;

    localparam int GELU_LUT_ADDR_W = 7;
    localparam int GELU_LUT_DATA_W = 16;

    // LUT segment bases inside the RAM, selected by the input exponent
    localparam logic [GELU_LUT_ADDR_W-1:0] GELU_LUT_SEG_BASE_NEG  = 7'h00; // exponent < 0
    localparam logic [GELU_LUT_ADDR_W-1:0] GELU_LUT_SEG_BASE_ZERO = 7'h20; // exponent == 0
    localparam logic [GELU_LUT_ADDR_W-1:0] GELU_LUT_SEG_BASE_ONE  = 7'h40; // exponent == 1

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } gelu_ld_state_t;

endpackage

// File: rtl/lut_checksum_acc.sv
// Modular running sum of LUT words. Used on the load side and on the
// readback side of the loader when readback verification is built in.
module lut_checksum_acc #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_add,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_sum
);

    logic [DATA_WIDTH-1:0] r_sum;

    // Clear has priority over add; the sum wraps at DATA_WIDTH bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_add) begin
            r_sum <= r_sum + i_data;
        end
    end

    assign o_sum = r_sum;

endmodule

// File: rtl/gelu_lut_loader.sv
// GELU LUT loader: writer side of the GELU LUT RAM.
// Takes a valid/ready stream of LUT words and writes them to consecutive
// RAM addresses (wrapping) starting at cfg_base.
// Handshake: a word is transferred in a cycle where vld_in and rdy_out are
// both high; rdy_out already includes en, so nothing moves while stalled,
// and data_in must be held until it has been transferred.
// Optional readback verification is built when GELU_LUT_VERIFY_EN is defined.
module gelu_lut_loader
    import sfu_pkg::*;
#(
    parameter int ADDR_WIDTH = GELU_LUT_ADDR_W,
    parameter int DATA_WIDTH = GELU_LUT_DATA_W,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  cfg_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  vld_in,
    output logic                  rdy_out,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_we,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  busy,
    output logic                  done,
    output logic                  lut_valid,
    output logic                  chk_err
);

    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(2 ** ADDR_WIDTH);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    gelu_ld_state_t r_state;
    gelu_ld_state_t w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_idx;
    logic                  r_wr_pend;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_lut_valid;

    logic [LEN_WIDTH-1:0]  w_len_clip;
    logic [LEN_WIDTH-1:0]  w_idx_inc;
    logic                  w_start;
    logic                  w_accept;
    logic                  w_last_beat;
    logic                  w_verify_end;
    logic                  w_mismatch;

    assign w_len_clip  = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    assign w_idx_inc   = r_idx + LEN_ONE;
    assign w_start     = en && (r_state == IDLE) && cfg_start;
    assign rdy_out     = en && (r_state == LOAD);
    assign w_accept    = vld_in && rdy_out;
    assign w_last_beat = w_accept && (w_idx_inc == r_len);

    // Next-state selection; the register below only advances when en is high
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = (w_len_clip == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (w_last_beat) begin
`ifdef GELU_LUT_VERIFY_EN
                    w_state_nxt = VERIFY;
`else
                    w_state_nxt = DONE;
`endif
                end
            end
            VERIFY: begin
                if (w_verify_end) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register, frozen while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (en) begin
            r_state <= w_state_nxt;
        end
    end

    // Load datapath: latch config, count beats, stage each accepted beat as
    // the next cycle's RAM write, and maintain the sticky lut_valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base      <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_wr_pend   <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_lut_valid <= 1'b0;
        end else if (en) begin
            r_wr_pend <= w_accept;
            if (w_start) begin
                r_base <= cfg_base;
                r_len  <= w_len_clip;
                r_idx  <= '0;
            end
            if (w_accept) begin
                r_wr_addr <= r_base + r_idx[ADDR_WIDTH-1:0];
                r_wr_data <= data_in;
                r_idx     <= w_idx_inc;
            end
            // Entering DONE publishes the result; a new start clears it
            if ((w_state_nxt == DONE) && (r_state != DONE)) begin
                r_lut_valid <= !w_mismatch;
            end else if (w_start) begin
                r_lut_valid <= 1'b0;
            end
        end
    end

`ifdef GELU_LUT_VERIFY_EN
    logic [LEN_WIDTH-1:0]  r_vcnt;
    logic                  r_rd_pend;
    logic                  r_chk_err;
    logic                  w_rd_issue;
    logic                  w_q_take;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic [DATA_WIDTH-1:0] w_ld_sum;
    logic [DATA_WIDTH-1:0] w_rd_sum;
    logic [DATA_WIDTH-1:0] w_rd_total;

    // Reads start once the final write has left the pipeline
    assign w_rd_issue   = en && (r_state == VERIFY) && !r_wr_pend && (r_vcnt != r_len);
    assign w_q_take     = en && (r_state == VERIFY) && r_rd_pend;
    assign w_rd_addr    = r_base + r_vcnt[ADDR_WIDTH-1:0];
    assign w_rd_total   = w_rd_sum + ram_q;
    assign w_verify_end = w_q_take && (r_vcnt == r_len);
    assign w_mismatch   = w_verify_end && (w_rd_total != w_ld_sum);

    // Readback sequencing and the sticky checksum error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vcnt    <= '0;
            r_rd_pend <= 1'b0;
            r_chk_err <= 1'b0;
        end else if (en) begin
            r_rd_pend <= w_rd_issue;
            if (w_start) begin
                r_vcnt    <= '0;
                r_chk_err <= 1'b0;
            end else if (w_rd_issue) begin
                r_vcnt <= r_vcnt + LEN_ONE;
            end
            if (w_mismatch) begin
                r_chk_err <= 1'b1;
            end
        end
    end

    lut_checksum_acc #(.DATA_WIDTH(DATA_WIDTH)) u_ld_sum (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start),
        .i_add   (w_accept),
        .i_data  (data_in),
        .o_sum   (w_ld_sum)
    );

    lut_checksum_acc #(.DATA_WIDTH(DATA_WIDTH)) u_rd_sum (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_start),
        .i_add   (w_q_take),
        .i_data  (ram_q),
        .o_sum   (w_rd_sum)
    );

    assign ram_re   = w_rd_issue;
    assign ram_addr = ((r_state == VERIFY) && !r_wr_pend) ? w_rd_addr : r_wr_addr;
    assign chk_err  = r_chk_err;
`else
    logic w_unused_q;

    // Unreachable without readback; lets a corrupted state fall back to DONE
    assign w_verify_end = 1'b1;
    assign w_mismatch   = 1'b0;
    assign w_unused_q   = ^ram_q;
    assign ram_re       = 1'b0;
    assign ram_addr     = r_wr_addr;
    assign chk_err      = 1'b0;
`endif

    assign ram_data  = r_wr_data;
    assign ram_we    = en && r_wr_pend;
    assign busy      = (r_state != IDLE);
    assign done      = en && (r_state == DONE);
    assign lut_valid = r_lut_valid;

endmodule

// File: tb/tb_gelu_lut_loader.sv
// Testbench for gelu_lut_loader: directed loads with a write scoreboard and a
// behavioural LUT RAM. Readback scenarios are included when
// GELU_LUT_VERIFY_EN is defined.
module tb_gelu_lut_loader;

  localparam int AW = 7;
  localparam int DW = 16;
  localparam int LW = 8;
`ifdef GELU_LUT_VERIFY_EN
  localparam int VERIFY_ON = 1;
`else
  localparam int VERIFY_ON = 0;
`endif

  // clock / reset and DUT signals
  logic          clk;
  logic          rst_n;
  logic          en;
  logic          cfg_start;
  logic [AW-1:0] cfg_base;
  logic [LW-1:0] cfg_len;
  logic [DW-1:0] data_in;
  logic          vld_in;
  logic          rdy_out;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] ram_q;
  logic          busy;
  logic          done;
  logic          lut_valid;
  logic          chk_err;

  int n_vec;
  int n_err;
  int cyc;
  int we_cnt;
  int start_cyc;
  bit corrupt_21;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    mem     [0:(1<<AW)-1];
  logic [DW-1:0]    exp_mem [0:(1<<AW)-1];

  gelu_lut_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_start (cfg_start),
    .cfg_base  (cfg_base),
    .cfg_len   (cfg_len),
    .data_in   (data_in),
    .vld_in    (vld_in),
    .rdy_out   (rdy_out),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_q     (ram_q),
    .busy      (busy),
    .done      (done),
    .lut_valid (lut_valid),
    .chk_err   (chk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // LUT RAM model; word 0x21 can be corrupted on write
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= (corrupt_21 && ram_addr == 7'h21) ? ~ram_data : ram_data;
    if (ram_re) ram_q <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: every RAM write must match the head of the expected queue
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rst_n && ram_we) begin
      we_cnt++;
      check("we_only_when_en", en, 1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", ram_addr, ram_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", ram_addr, e[AW+DW-1:DW]);
        check("wr_data", ram_data, e[DW-1:0]);
      end
    end
  end

  function automatic int lat(input int len);
    return len + 1 + ((VERIFY_ON != 0 && len > 0) ? len + 2 : 0);
  endfunction

  task automatic start(input logic [AW-1:0] b, input logic [LW-1:0] l);
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_base = b; cfg_len = l; start_cyc = cyc;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  // driver: present one beat (after an optional random gap) until accepted
  task automatic send_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input int max_gap);
    int   gap;
    logic acc;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    if (gap > 0) begin
      vld_in = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    vld_in = 1'b1; data_in = d; acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk); acc = rdy_out;
      @(posedge clk); #1;
    end
    if (acc) begin
      exp_q.push_back({a, d});
      exp_mem[a] = d;
    end else begin
      n_vec++; n_err++;
      $display("FAIL beat_accept_timeout: got no rdy_out expected accept of addr %0h", a);
    end
  endtask

  task automatic wait_done(input string name, input int exp_lat, input logic exp_valid,
                           input logic exp_chk);
    logic seen;
    seen = 1'b0;
    vld_in = 1'b0;
    for (int t = 0; t < 3000 && !seen; t++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL %s_done_timeout: got no done expected done pulse", name);
    end else begin
      if (exp_lat >= 0) check({name, "_latency"}, cyc - start_cyc, exp_lat);
      check({name, "_lut_valid"}, lut_valid, exp_valid);
      check({name, "_chk_err"}, chk_err, exp_chk);
      @(negedge clk);
      check({name, "_busy_after"}, busy, 0);
      check({name, "_done_single"}, done, 0);
      check({name, "_queue_empty"}, exp_q.size(), 0);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_rdy"}, rdy_out, 0);
    check({name, "_we"}, ram_we, 0);
    check({name, "_re"}, ram_re, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_lut_valid"}, lut_valid, 0);
    check({name, "_chk_err"}, chk_err, 0);
    check({name, "_addr"}, ram_addr, 0);
    check({name, "_data"}, ram_data, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w0;
    logic [AW-1:0] a;
    n_vec = 0; n_err = 0; cyc = 0; we_cnt = 0; corrupt_21 = 1'b0;
    rst_n = 1'b0; en = 1'b1; cfg_start = 1'b0; cfg_base = '0; cfg_len = '0;
    data_in = '0; vld_in = 1'b0;
    for (int k = 0; k < (1 << AW); k++) mem[k] = '0;
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // full load: 96 back-to-back words, data = i*3
    w0 = we_cnt;
    start(7'h00, 8'd96);
    for (int i = 0; i < 96; i++) send_beat(AW'(i), DW'(i * 3), 0);
    wait_done("full", lat(96), 1'b1, 1'b0);
    check("full_write_count", we_cnt - w0, 96);
    for (int i = 0; i < 96; i += 19) check("full_ram", mem[i], DW'(i * 3));

    // wrap: base 0x7E, len 4 writes 0x7E, 0x7F, 0x00, 0x01
    start(7'h7E, 8'd4);
    for (int i = 0; i < 4; i++) begin
      a = AW'(7'h7E + i);
      send_beat(a, DW'(16'hA000 + i), 0);
    end
    wait_done("wrap", lat(4), 1'b1, 1'b0);
    check("wrap_ram_00", mem[0], 16'hA002);
    check("wrap_ram_7f", mem[127], 16'hA001);

    // zero length: done the cycle after start, no writes
    w0 = we_cnt;
    start(7'h10, 8'd0);
    wait_done("zero", 1, 1'b1, 1'b0);
    check("zero_no_writes", we_cnt - w0, 0);

    // backpressure and a 5-cycle stall mid-load
    w0 = we_cnt;
    start(7'h05, 8'd20);
    fork
      for (int i = 0; i < 20; i++) send_beat(AW'(5 + i), DW'(16'h3C00 ^ (i * 77)), 3);
      begin
        repeat (8) @(posedge clk);
        #1 en = 1'b0;
        repeat (5) @(posedge clk);
        #1 en = 1'b1;
      end
    join
    wait_done("stall", -1, 1'b1, 1'b0);
    check("stall_write_count", we_cnt - w0, 20);
    for (int i = 0; i < 20; i++) check("stall_ram", mem[5 + i], exp_mem[5 + i]);

    // reset after 10 of 32 beats, then a clean reload
    start(7'h10, 8'd32);
    for (int i = 0; i < 10; i++) send_beat(AW'(16 + i), DW'(16'h7700 + i), 0);
    rst_n = 1'b0; vld_in = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    start(7'h10, 8'd32);
    for (int i = 0; i < 32; i++) send_beat(AW'(16 + i), DW'(16'h5500 + i), 0);
    wait_done("reload", lat(32), 1'b1, 1'b0);

    // start pulse during LOAD must be ignored
    start(7'h40, 8'd8);
    for (int i = 0; i < 3; i++) send_beat(AW'(7'h40 + i), DW'(16'h1230 + i), 0);
    vld_in = 1'b0; cfg_start = 1'b1; cfg_base = 7'h00; cfg_len = 8'd3;
    @(posedge clk); #1 cfg_start = 1'b0;
    check("busy_ignores_start", busy, 1);
    for (int i = 3; i < 8; i++) send_beat(AW'(7'h40 + i), DW'(16'h1230 + i), 0);
    wait_done("busy_start", -1, 1'b1, 1'b0);

`ifdef GELU_LUT_VERIFY_EN
    // readback: clean run, then a run with word 0x21 corrupted
    start(7'h20, 8'd8);
    for (int i = 0; i < 8; i++) send_beat(AW'(7'h20 + i), DW'(16'h0100 + i), 0);
    wait_done("verify_clean", lat(8), 1'b1, 1'b0);
    corrupt_21 = 1'b1;
    start(7'h20, 8'd8);
    for (int i = 0; i < 8; i++) send_beat(AW'(7'h20 + i), DW'(16'h0200 + i), 0);
    wait_done("verify_bad", lat(8), 1'b0, 1'b1);
    corrupt_21 = 1'b0;
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
